// File: rtl/expr_pkg.sv
// expr_pkg: state encodings, ASCII constants and character classes for the expr recognizer
package expr_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        NUM  = 2'd1,
        OP   = 2'd2,
        ERR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CL_DIGIT = 2'd0,
        CL_OP    = 2'd1,
        CL_OTHER = 2'd2
    } char_class_t;

    localparam logic [7:0] CH_0     = 8'd48;
    localparam logic [7:0] CH_9     = 8'd57;
    localparam logic [7:0] CH_PLUS  = 8'd43;
    localparam logic [7:0] CH_MUL   = 8'd42;
    localparam logic [7:0] CH_MINUS = 8'd45;
    localparam logic [7:0] CH_DIV   = 8'd47;

endpackage

// File: rtl/expr_char_class.sv
// expr_char_class: combinational ASCII classifier; EXPR_EXT_OPS_EN adds '-' and '/' as operators
module expr_char_class
    import expr_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] in,
    output char_class_t       cls
);

    logic ext_op;

`ifdef EXPR_EXT_OPS_EN
    assign ext_op = (in == CH_MINUS) || (in == CH_DIV);
`else
    assign ext_op = 1'b0;
`endif

    always_comb begin
        cls = (in >= CH_0 && in <= CH_9) ? CL_DIGIT :
              (in == CH_PLUS || in == CH_MUL || ext_op) ? CL_OP : CL_OTHER;
    end

endmodule

// File: rtl/expr.sv
// expr: Moore recognizer for digit (op digit)*; clr is a synchronous active-low clear; EXPR_EXT_OPS_EN widens the operator set
module expr
    import expr_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] in,
    output logic              out
);

    state_t      state_q, state_d;
    char_class_t cls;

    expr_char_class #(.DATA_W(DATA_W)) u_class (
        .in (in),
        .cls(cls)
    );

    // INIT and OP share the same rule: a digit completes a term, anything else is fatal
    always_comb begin
        state_d = (state_q == ERR) ? ERR :
                  (state_q == NUM) ? ((cls == CL_OP) ? OP : ERR) :
                  ((cls == CL_DIGIT) ? NUM : ERR);
    end

    always_ff @(posedge clk) begin
        if (!clr) state_q <= INIT;
        else      state_q <= state_d;
    end

    assign out = (state_q == NUM);

endmodule

// File: tb/tb_expr.sv
// tb_expr: table-driven directed check of the expr recognizer plus clear/latency sequences
module tb_expr;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] in  = 8'd0;
    logic       out;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       clr;
        logic [7:0] ch;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    expr #(.DATA_W(8)) dut (
        .clk(clk),
        .clr(clr),
        .in (in),
        .out(out)
    );

    always #5 clk = ~clk;

    task automatic add(input logic c, input logic [7:0] ch, input logic e);
        vec_t v;
        v.clr = c;
        v.ch  = ch;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic exp);
        checks++;
        if (out !== exp) begin
            failures++;
            $display("FAIL %s: out=%b expected=%b", name, out, exp);
        end
    endtask

    task automatic step(input logic c, input logic [7:0] ch);
        @(negedge clk);
        clr = c;
        in  = ch;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ext;
`ifdef EXPR_EXT_OPS_EN
        ext = 1'b1;
`else
        ext = 1'b0;
`endif
        add(0, 8'd0, 0);
        // "1+2*3" then 3 held: NUM, then sticky ERR
        add(1, 8'd49, 1); add(1, 8'd43, 0); add(1, 8'd50, 1); add(1, 8'd42, 0);
        add(1, 8'd51, 1); add(1, 8'd51, 0); add(1, 8'd51, 0);
        add(0, 8'd97, 0);
        add(1, 8'd49, 1); add(1, 8'd43, 0); add(1, 8'd50, 1); add(1, 8'd42, 0);
        add(1, 8'd51, 1);
        add(0, 8'd0, 0);
        add(1, 8'd43, 0); add(1, 8'd49, 0); add(1, 8'd50, 0);
        add(0, 8'd0, 0);
        add(1, 8'd49, 1); add(1, 8'd50, 0); add(1, 8'd43, 0);
        add(0, 8'd0, 0);
        add(1, 8'd51, 1); add(1, 8'd43, 0); add(1, 8'd97, 0); add(1, 8'd52, 0);
        // clr with a digit present: the digit is discarded
        add(0, 8'd49, 0);
        add(1, 8'd55, 1); add(1, 8'd45, 0); add(1, 8'd56, ext); add(1, 8'd47, 0);
        add(1, 8'd57, ext);
        // class boundaries: '0','9' digits; '/' ':' ')' ',' not (in default build)
        add(0, 8'd0, 0);
        add(1, 8'd48, 1); add(1, 8'd42, 0); add(1, 8'd57, 1);
        add(0, 8'd0, 0); add(1, 8'd58, 0);
        add(0, 8'd0, 0); add(1, 8'd47, 0);
        add(0, 8'd0, 0); add(1, 8'd49, 1); add(1, 8'd41, 0);
        add(0, 8'd0, 0); add(1, 8'd49, 1); add(1, 8'd44, 0);
        add(0, 8'd0, 0); add(1, 8'd49, 1); add(1, 8'd46, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].clr, vecs[i].ch);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // out is registered: changing in mid-cycle must not move it
        step(0, 8'd0);
        step(1, 8'd53);
        check("num_before_glitch", 1'b1);
        in = 8'd97;
        #2;
        check("no_comb_path", 1'b1);

        // clr held low several cycles from NUM, then first char restarts
        for (int i = 0; i < 3; i++) begin
            step(0, 8'd54);
            check($sformatf("clr_hold%0d", i), 1'b0);
        end
        step(1, 8'd54);
        check("first_after_clr", 1'b1);
        step(1, 8'd42);
        check("op_after_restart", 1'b0);
        step(0, 8'd54);
        check("clr_from_op", 1'b0);
        step(1, 8'd54);
        check("digit_after_clr_from_op", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
